match_ctrl: RTL and testbench

Match sequencer for the pong datapath. It debounces the player start button and runs the serve countdown. It issues the one-cycle `start` pulse to the ball engine and watches the engine's free-running `score1`/`score2` outputs to keep a per-match score, ending the match at a target score. It sits between the board button/top level and the ball engine, and its state and score outputs feed the score/overlay renderer.

---
 rtl/match_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_match_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/match_ctrl.sv
// match_ctrl: match sequencer for the pong datapath.
// Debounces the start button, runs the serve countdown, fires the one-cycle
// serve pulse into the ball engine and turns the engine's free-running score
// counters into per-match points, ending the match at WIN_SCORE.
module match_ctrl #(
  parameter int DEBOUNCE_CLKS    = 250_000,
  parameter int SERVE_DELAY_CLKS = 25_000_000,
  parameter int POINT_HOLD_CLKS  = 12_500_000,
  parameter int WIN_SCORE        = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic [3:0] score1_in,
  input  logic [3:0] score2_in,
  output logic       ball_start,
  output logic [2:0] game_state,
  output logic [1:0] countdown,
  output logic [3:0] match1,
  output logic [3:0] match2,
  output logic [1:0] winner
);

  localparam int TIMER_MAX = (SERVE_DELAY_CLKS > POINT_HOLD_CLKS) ? SERVE_DELAY_CLKS : POINT_HOLD_CLKS;
  localparam int TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;
  localparam int DB_W      = (DEBOUNCE_CLKS > 1) ? $clog2(DEBOUNCE_CLKS) : 1;

  localparam logic [TIMER_W-1:0] SERVE_LAST = TIMER_W'(SERVE_DELAY_CLKS - 1);
  localparam logic [TIMER_W-1:0] POINT_LAST = TIMER_W'(POINT_HOLD_CLKS - 1);
  localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CLKS - 1);
  localparam logic [3:0]         WIN        = 4'(WIN_SCORE);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SERVE    = 3'd1,
    PLAY     = 3'd2,
    POINT    = 3'd3,
    GAMEOVER = 3'd4
  } state_e;

  logic              sync1_q, sync2_q;
  logic [DB_W-1:0]   dbCnt_q, dbCnt_d;
  logic              dbLevel_q, dbLevel_d;
  logic              dbPrev_q;
  logic              press;

  logic [3:0]        prev1_q, prev2_q;
  logic              primed_q;
  logic              evt1, evt2;

  state_e            state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [1:0]        countdown_q, countdown_d;
  logic [3:0]        match1_q, match1_d;
  logic [3:0]        match2_q, match2_d;
  logic [1:0]        winner_q, winner_d;
  logic              ballStart_q, ballStart_d;
  logic [3:0]        match1Inc, match2Inc;

  // Two-flop synchronizer for the raw asynchronous button level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= start_btn;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: accept the synced level only after it disagrees for DEBOUNCE_CLKS cycles
  always_comb begin
    dbCnt_d   = dbCnt_q;
    dbLevel_d = dbLevel_q;
    if (sync2_q == dbLevel_q) begin
      dbCnt_d = '0;
    end else if (dbCnt_q == DB_LAST) begin
      dbLevel_d = sync2_q;
      dbCnt_d   = '0;
    end else begin
      dbCnt_d = dbCnt_q + DB_W'(1);
    end
  end

  // Debounce registers plus a delayed copy of the level for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbCnt_q   <= '0;
      dbLevel_q <= 1'b0;
      dbPrev_q  <= 1'b0;
    end else begin
      dbCnt_q   <= dbCnt_d;
      dbLevel_q <= dbLevel_d;
      dbPrev_q  <= dbLevel_q;
    end
  end

  assign press = dbLevel_q & ~dbPrev_q;

  // Track engine scores every cycle; the first cycle out of reset only primes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev1_q  <= 4'd0;
      prev2_q  <= 4'd0;
      primed_q <= 1'b0;
    end else begin
      prev1_q  <= score1_in;
      prev2_q  <= score2_in;
      primed_q <= 1'b1;
    end
  end

  assign evt1 = primed_q && (score1_in != prev1_q);
  assign evt2 = primed_q && (score2_in != prev2_q);

  assign match1Inc = (evt1 && (match1_q < WIN)) ? match1_q + 4'd1 : match1_q;
  assign match2Inc = (evt2 && (match2_q < WIN)) ? match2_q + 4'd1 : match2_q;

  // State register and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      countdown_q <= 2'd0;
      match1_q    <= 4'd0;
      match2_q    <= 4'd0;
      winner_q    <= 2'd0;
      ballStart_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      countdown_q <= countdown_d;
      match1_q    <= match1_d;
      match2_q    <= match2_d;
      winner_q    <= winner_d;
      ballStart_q <= ballStart_d;
    end
  end

  // Next-state logic: serve countdown, point crediting and match end
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    countdown_d = countdown_q;
    match1_d    = match1_q;
    match2_d    = match2_q;
    winner_d    = winner_q;
    ballStart_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (press) begin
          match1_d    = 4'd0;
          match2_d    = 4'd0;
          winner_d    = 2'd0;
          countdown_d = 2'd3;
          timer_d     = '0;
          state_d     = SERVE;
        end
      end
      SERVE: begin
        if (timer_q == SERVE_LAST) begin
          timer_d = '0;
          if (countdown_q == 2'd1) begin
            countdown_d = 2'd0;
            ballStart_d = 1'b1;
            state_d     = PLAY;
          end else begin
            countdown_d = countdown_q - 2'd1;
          end
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      PLAY: begin
        if (evt1 || evt2) begin
          match1_d = match1Inc;
          match2_d = match2Inc;
          if (match1Inc >= WIN) begin
            winner_d = 2'd1;
            state_d  = GAMEOVER;
          end else if (match2Inc >= WIN) begin
            winner_d = 2'd2;
            state_d  = GAMEOVER;
          end else begin
            timer_d = '0;
            state_d = POINT;
          end
        end
      end
      POINT: begin
        if (timer_q == POINT_LAST) begin
          timer_d     = '0;
          countdown_d = 2'd3;
          state_d     = SERVE;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      GAMEOVER: begin
        if (press) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs come straight from registers so the renderer sees glitch-free values
  always_comb begin
    ball_start = ballStart_q;
    game_state = state_q;
    countdown  = countdown_q;
    match1     = match1_q;
    match2     = match2_q;
    winner     = winner_q;
  end

endmodule

// File: tb/tb_match_ctrl.sv
// tb_match_ctrl: directed match sequence with randomized scoring, checked
// against a points-and-timing model of the match rules.
module tb_match_ctrl;

  localparam int DB = 4;
  localparam int SD = 10;
  localparam int PH = 5;
  localparam int WS = 3;

  logic       clk;
  logic       rst;
  logic       start_btn;
  logic [3:0] score1_in;
  logic [3:0] score2_in;
  logic       ball_start;
  logic [2:0] game_state;
  logic [1:0] countdown;
  logic [3:0] match1;
  logic [3:0] match2;
  logic [1:0] winner;

  int nCompared = 0;
  int nMismatch = 0;

  // Reference model: engine counter values and match tallies
  int e1, e2;
  int m1, m2, win;

  match_ctrl #(
    .DEBOUNCE_CLKS   (DB),
    .SERVE_DELAY_CLKS(SD),
    .POINT_HOLD_CLKS (PH),
    .WIN_SCORE       (WS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start_btn (start_btn),
    .score1_in (score1_in),
    .score2_in (score2_in),
    .ball_start(ball_start),
    .game_state(game_state),
    .countdown (countdown),
    .match1    (match1),
    .match2    (match2),
    .winner    (winner)
  );

  // 100 MHz-style free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic driveScores();
    score1_in = 4'(e1);
    score2_in = 4'(e2);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp)
      else begin
        nMismatch++;
        $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
  endtask

  function automatic int satAdd(input int m, input int ev);
    return (m + ev > WS) ? WS : m + ev;
  endfunction

  // Engine scores a point for the selected players (counters wrap at 16)
  task automatic applyStimulus(input int ev1, input int ev2);
    e1 = (e1 + ev1) % 16;
    e2 = (e2 + ev2) % 16;
    driveScores();
  endtask

  // Wait for the serve pulse; n counts cycles since SERVE entry
  task automatic waitBall(input int already, output int n);
    n = already;
    while (ball_start !== 1'b1 && n < 40) begin
      tick(1);
      n++;
    end
  endtask

  task automatic waitPlay(input int already);
    int n;
    waitBall(already, n);
    checkOutput("serve_to_ball_start", n, 3 * SD);
    checkOutput("play_state", game_state, 2);
    checkOutput("play_countdown", countdown, 0);
    tick(1);
    checkOutput("ball_start_single", ball_start, 0);
  endtask

  // Clean 6-cycle press; the state changes 7 cycles after the raw edge
  task automatic pressButton(input int expState);
    start_btn = 1'b1;
    tick(DB + 2);
    start_btn = 1'b0;
    tick(1);
    checkOutput("press_state", game_state, expState);
    tick(DB + 2);
  endtask

  task automatic scorePoint(input int ev1, input int ev2);
    applyStimulus(ev1, ev2);
    m1 = satAdd(m1, ev1);
    m2 = satAdd(m2, ev2);
    if (m1 >= WS) win = 1;
    else if (m2 >= WS) win = 2;
    tick(1);
    checkOutput("point_match1", match1, m1);
    checkOutput("point_match2", match2, m2);
    checkOutput("point_winner", winner, win);
    checkOutput("point_state", game_state, (win != 0) ? 4 : 3);
    if (win == 0) begin
      tick(PH - 1);
      checkOutput("point_hold", game_state, 3);
      tick(1);
      checkOutput("point_to_serve", game_state, 1);
      checkOutput("point_countdown", countdown, 3);
      waitPlay(0);
    end
  endtask

  initial begin
    int n;
    int r;
    rst = 1'b1;
    start_btn = 1'b0;
    e1 = 9;
    e2 = 5;
    m1 = 0;
    m2 = 0;
    win = 0;
    driveScores();
    tick(3);
    checkOutput("reset_state", game_state, 0);
    checkOutput("reset_ball", ball_start, 0);
    checkOutput("reset_countdown", countdown, 0);
    checkOutput("reset_match1", match1, 0);
    checkOutput("reset_match2", match2, 0);
    checkOutput("reset_winner", winner, 0);
    rst = 1'b0;
    tick(2);

    // Bouncy button: 3-cycle highs never get accepted
    for (int i = 0; i < 3; i++) begin
      start_btn = 1'b1;
      tick(3);
      start_btn = 1'b0;
      tick(2);
    end
    tick(6);
    checkOutput("bounce_ignored", game_state, 0);

    // Clean press and the full serve countdown
    start_btn = 1'b1;
    tick(6);
    checkOutput("press_latency_early", game_state, 0);
    start_btn = 1'b0;
    tick(1);
    checkOutput("press_latency", game_state, 1);
    checkOutput("serve_cd3", countdown, 3);
    tick(SD - 1);
    checkOutput("serve_cd3_hold", countdown, 3);
    tick(1);
    checkOutput("serve_cd2", countdown, 2);
    tick(SD - 1);
    checkOutput("serve_cd2_hold", countdown, 2);
    tick(1);
    checkOutput("serve_cd1", countdown, 1);
    tick(SD - 1);
    checkOutput("serve_last_state", game_state, 1);
    checkOutput("serve_last_ball", ball_start, 0);
    tick(1);
    checkOutput("first_play_state", game_state, 2);
    checkOutput("first_play_ball", ball_start, 1);
    checkOutput("first_play_cd", countdown, 0);
    tick(1);
    checkOutput("ball_pulse_end", ball_start, 0);

    // First real increment after the 9/5 preset credits exactly one point
    applyStimulus(0, 1);
    m2 = 1;
    tick(1);
    checkOutput("p2_match2", match2, 1);
    checkOutput("p2_match1", match1, 0);
    checkOutput("p2_state", game_state, 3);
    tick(1);
    e1 = 15;
    driveScores();
    tick(PH - 2);
    checkOutput("point_ignore_state", game_state, 3);
    checkOutput("point_ignore_match1", match1, 0);
    tick(1);
    checkOutput("point_exit_state", game_state, 1);
    checkOutput("point_exit_cd", countdown, 3);
    e2 = (e2 + 1) % 16;
    driveScores();
    waitPlay(0);
    checkOutput("serve_ignore_match1", match1, 0);
    checkOutput("serve_ignore_match2", match2, 1);

    // Player 1 wins through a 15 -> 0 wrap
    scorePoint(1, 0);
    scorePoint(1, 0);
    scorePoint(1, 0);
    tick(3);
    checkOutput("gameover_hold_state", game_state, 4);
    checkOutput("gameover_hold_winner", winner, 1);
    pressButton(0);
    checkOutput("idle_keep_match1", match1, 3);
    checkOutput("idle_keep_match2", match2, 1);
    checkOutput("idle_keep_winner", winner, 1);
    pressButton(1);
    m1 = 0;
    m2 = 0;
    win = 0;
    checkOutput("restart_match1", match1, 0);
    checkOutput("restart_match2", match2, 0);
    checkOutput("restart_winner", winner, 0);
    checkOutput("restart_cd", countdown, 3);
    waitPlay(DB + 2);

    // Randomized match, including simultaneous points
    for (int i = 0; i < 20 && win == 0; i++) begin
      r = int'($urandom_range(2));
      scorePoint((r != 1) ? 1 : 0, (r != 0) ? 1 : 0);
    end
    checkOutput("random_match_over", game_state, 4);
    pressButton(0);
    pressButton(1);
    m1 = 0;
    m2 = 0;
    win = 0;

    // Reset in the middle of SERVE
    tick(12);
    rst = 1'b1;
    #1;
    checkOutput("rst_serve_state", game_state, 0);
    checkOutput("rst_serve_cd", countdown, 0);
    checkOutput("rst_serve_ball", ball_start, 0);
    e1 = int'($urandom_range(15));
    e2 = int'($urandom_range(15));
    driveScores();
    tick(2);
    rst = 1'b0;
    tick(3);
    checkOutput("rst_serve_idle", game_state, 0);

    // Reset right on the serve pulse in PLAY
    pressButton(1);
    waitBall(DB + 2, n);
    checkOutput("rst_play_ball_seen", ball_start, 1);
    rst = 1'b1;
    #1;
    checkOutput("rst_play_ball", ball_start, 0);
    checkOutput("rst_play_state", game_state, 0);
    tick(2);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checkOutput("rst_no_leak", ball_start, 0);
    end

    // After re-priming, the first simultaneous point credits both players once
    pressButton(1);
    waitPlay(DB + 2);
    scorePoint(1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
